// File: rtl/red_led_pwm_driver_if.sv
// LED PWM driver bus: PIO-side inputs and LEDR-side outputs grouped together.
interface red_led_pwm_driver_if #(
   parameter int unsigned WIDTH = 18
);
   logic [WIDTH-1:0] led_word;
   logic [3:0]       brightness;
   logic             blink_en;
   logic [WIDTH-1:0] led_out;
   logic             frame_start;
   logic             blink_phase;

   // Master drives the LED word and controls, observes the pin drive.
   modport master (
      output led_word, brightness, blink_en,
      input  led_out, frame_start, blink_phase
   );

   // Slave is the PWM driver itself.
   modport slave (
      input  led_word, brightness, blink_en,
      output led_out, frame_start, blink_phase
   );
endinterface

// File: rtl/red_led_pwm_driver.sv
// Red-LED PWM driver: 15-slot brightness PWM with optional frame-aligned blinking.
// LED word and controls are shadowed only at frame boundaries to avoid glitches.
module red_led_pwm_driver #(
   parameter int unsigned WIDTH        = 18,
   parameter int unsigned PRESCALE     = 195,
   parameter int unsigned BLINK_FRAMES = 8012
) (
   input logic                 clk,
   input logic                 reset,
   red_led_pwm_driver_if.slave bus
);

   localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int unsigned BcW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [PreW-1:0]  pre_cnt_q, pre_cnt_d;
   logic [3:0]       slot_cnt_q, slot_cnt_d;
   logic [BcW-1:0]   bc_q, bc_d;
   logic             blink_phase_q, blink_phase_d;
   logic [WIDTH-1:0] sh_word_q, sh_word_d;
   logic [3:0]       sh_bright_q, sh_bright_d;
   logic             sh_blink_q, sh_blink_d;
   logic [WIDTH-1:0] led_out_q, led_out_d;

   logic slot_tick;
   logic frame_hit;
   logic led_on;

   // Next-state: prescaler, slot counter, shadow load, blink counter and output drive.
   always_comb begin
      slot_tick     = (pre_cnt_q == PreW'(PRESCALE - 1));
      frame_hit     = (pre_cnt_q == '0) && (slot_cnt_q == 4'd0);

      pre_cnt_d     = slot_tick ? '0 : pre_cnt_q + PreW'(1);
      slot_cnt_d    = slot_cnt_q;
      sh_word_d     = sh_word_q;
      sh_bright_d   = sh_bright_q;
      sh_blink_d    = sh_blink_q;
      bc_d          = bc_q;
      blink_phase_d = blink_phase_q;

      if (slot_tick) begin
         slot_cnt_d = (slot_cnt_q == 4'd14) ? 4'd0 : slot_cnt_q + 4'd1;
      end

      // Blink counter runs regardless of blink_en so the phase stays frame-aligned.
      if (frame_hit) begin
         sh_word_d   = bus.led_word;
         sh_bright_d = bus.brightness;
         sh_blink_d  = bus.blink_en;
         if (bc_q == BcW'(BLINK_FRAMES - 1)) begin
            bc_d          = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            bc_d = bc_q + BcW'(1);
         end
      end

      // brightness 15 is always on since slot_cnt never exceeds 14.
      led_on    = (slot_cnt_q < sh_bright_q) && !(sh_blink_q && blink_phase_q);
      led_out_d = led_on ? sh_word_q : '0;
   end

   // State registers with asynchronous active-high reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_cnt_q     <= '0;
         slot_cnt_q    <= 4'd0;
         bc_q          <= '0;
         blink_phase_q <= 1'b0;
         sh_word_q     <= '0;
         sh_bright_q   <= 4'd0;
         sh_blink_q    <= 1'b0;
         led_out_q     <= '0;
      end else begin
         pre_cnt_q     <= pre_cnt_d;
         slot_cnt_q    <= slot_cnt_d;
         bc_q          <= bc_d;
         blink_phase_q <= blink_phase_d;
         sh_word_q     <= sh_word_d;
         sh_bright_q   <= sh_bright_d;
         sh_blink_q    <= sh_blink_d;
         led_out_q     <= led_out_d;
      end
   end

   // Counters sit at zero while reset is held, so the boundary decode is masked by reset.
   assign bus.frame_start = frame_hit & ~reset;
   assign bus.blink_phase = blink_phase_q;
   assign bus.led_out     = led_out_q;

endmodule

// File: doc/red_led_pwm_driver.md
Name: red_led_pwm_driver

Overview:
Sits directly downstream of the 18-bit red-LED PIO and consumes its out_port word. Drives the physical LEDR pins with global brightness control (15-level PWM) and optional blinking. The LED word and control inputs are captured only at PWM frame boundaries, so software writes never produce partial-frame glitches.

Parameters:
WIDTH, 18, number of LED channels (matches PIO out_port width)
PRESCALE, 195, clk cycles per PWM slot; must be >= 1
BLINK_FRAMES, 8012, PWM frames per blink half-period; must be >= 1

Ports:
clk  input  1  system clock
reset  input  1  asynchronous reset, active-high
led_word  input  WIDTH  LED on/off word from PIO out_port
brightness  input  4  duty level: 0 = off, 15 = fully on
blink_en  input  1  1 = blank outputs during the off half of the blink cycle
led_out  output  WIDTH  registered drive to LEDR pins
frame_start  output  1  one-cycle pulse marking the PWM frame boundary / shadow load
blink_phase  output  1  current blink half: 0 = on half, 1 = off half

Behaviour:
- Clocking and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: led_out=0, frame_start=0, blink_phase=0, and all counters and shadow registers are 0.
- Prescaler:
  - pre_cnt counts 0..PRESCALE-1 and wraps to 0.
  - slot_tick is decoded as pre_cnt==PRESCALE-1.
- Slot counter:
  - slot_cnt counts 0..14 and advances only on slot_tick.
  - 14 wraps to 0.
  - One frame = 15*PRESCALE cycles.
- frame_start:
  - Decoded from the registers as pre_cnt==0 && slot_cnt==0.
  - Therefore high in the first cycle after reset release, then exactly once per frame.
- Shadow load:
  - At the clk edge ending a cycle with frame_start=1, load sh_word<=led_word, sh_bright<=brightness, sh_blink<=blink_en.
  - Input changes at any other time are ignored until the next frame_start.
- Blink counter:
  - Blink counter bc advances at the same edge as the shadow load (frame_start cycles only).
  - If bc==BLINK_FRAMES-1: bc<=0 and blink_phase toggles.
  - Otherwise bc increments.
  - The counter runs even when blink_en=0, so blink phase stays frame-aligned.
- Output:
  - on = (slot_cnt < sh_bright) && !(sh_blink && blink_phase).
  - led_out <= on ? sh_word : 0 (registered).
  - Latency: led_out in cycle t+1 reflects slot_cnt, blink_phase and shadow values of cycle t.
  - The first frame after reset uses shadow values loaded at the first frame_start, so led_out shows the new word from cycle 2 after release.
- Duty:
  - brightness=b gives b*PRESCALE high cycles per frame, aligned to the frame start.
  - b=15 means always on (slot_cnt max is 14).
  - b=0 means always off.
- Simultaneous events:
  - An input change in the same cycle as frame_start is captured (new value wins).
  - A blink toggle and a shadow load in the same edge both take effect.
  - The next cycle's on uses the new sh_blink and the new blink_phase.
- Reset mid-frame: everything returns to reset values immediately (asynchronous). No partial frame resumes; the frame restarts from slot 0 on release.
- Arithmetic:
  - pre_cnt width is clog2(PRESCALE), minimum 1.
  - slot_cnt is 4 bits.
  - bc width is clog2(BLINK_FRAMES), minimum 1.
  - The compare slot_cnt < sh_bright is unsigned 4-bit.

Test Plan:
(The bench uses PRESCALE=2, BLINK_FRAMES=3, giving a frame length of 30 cycles.)
1. Reset behaviour:
   - Stimulus: pulse reset for 3 cycles mid-frame, with brightness=15 and led_word=0x3FFFF.
   - Required: led_out=0 and frame_start=0 during reset; frame_start=1 in the first cycle after release; led_out=0x3FFFF from cycle 2; frame_start repeats every 30 cycles.
2. Full brightness:
   - Stimulus: brightness=15, blink_en=0, led_word=0x2AAAA.
   - Required: led_out is constant 0x2AAAA after load, with no low cycles.
3. Partial duty:
   - Stimulus: brightness=5, led_word=0x3FFFF.
   - Required: each frame, led_out=0x3FFFF for exactly 10 cycles starting 1 cycle after frame_start, then 0 for 20 cycles.
4. Mid-frame change:
   - Stimulus: brightness=15; change led_word from 0x00001 to 0x20000 at cycle 12 of a frame.
   - Required: led_out stays 0x00001 until 1 cycle after the next frame_start, then reads 0x20000. A change presented exactly in the frame_start cycle appears 1 cycle later.
5. Blink:
   - Stimulus: blink_en=1, brightness=15, led_word=0x0F0F0.
   - Required: blink_phase toggles every 90 cycles; led_out is 0x0F0F0 for 90 cycles, then 0 for 90 cycles, repeating.
   - Then set blink_en=0: outputs stay on from the next frame load onward.
6. Brightness zero:
   - Stimulus: brightness=0, led_word=0x3FFFF, blink_en set to either value.
   - Required: led_out=0 for at least 10 frames.
